// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory-side controller: MAR/MDR, wait-state access sequencing, memory-mapped
// keyboard/display/machine-control registers, and SRAM sharing with a program loader.
module lc3_mem_ctrl #(
    parameter int          WAIT_STATES = 2,
    parameter logic [15:0] DEV_BASE    = 16'hFE00
) (
    input  logic        clk,
    input  logic        arst_n,
    inout  wire  [15:0] bus,
    input  logic        ld_mar,
    input  logic        ld_mdr,
    input  logic        gate_mdr,
    input  logic        mio_en,
    input  logic        rw,
    output logic        rdy,
    output logic [15:0] sram_addr,
    output logic [15:0] sram_wdata,
    input  logic [15:0] sram_rdata,
    output logic        sram_we,
    input  logic        ldr_req,
    output logic        ldr_gnt,
    input  logic        ldr_we,
    input  logic [15:0] ldr_addr,
    input  logic [15:0] ldr_wdata,
    output logic [15:0] ldr_rdata,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        kb_int,
    output logic        dsp_valid,
    output logic [7:0]  dsp_data,
    input  logic        dsp_ack,
    output logic        mcr_run
);

    localparam int N_DEV    = 5;
    localparam int DEV_KBSR = 0;
    localparam int DEV_KBDR = 1;
    localparam int DEV_DSR  = 2;
    localparam int DEV_DDR  = 3;
    localparam int DEV_MCR  = 4;
    localparam logic [15:0] DEV_ADDR [N_DEV] = '{
        16'hFE00, 16'hFE02, 16'hFE04, 16'hFE06, 16'hFFFE
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_LOAD
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;

    logic [15:0] mar_reg;
    logic [15:0] mdr_reg;
    logic        kb_ready_reg;
    logic        kb_ie_reg;
    logic [7:0]  kbdr_reg;
    logic        dsr_ready_reg;
    logic [15:0] ddr_reg;
    logic        dsp_valid_reg;
    logic [15:0] mcr_reg;

    logic             mar_is_mem;
    logic [N_DEV-1:0] dev_sel;
    logic [15:0]      dev_rdata;
    logic [15:0]      rd_data;
    logic             cpu_rd_done;
    logic             cpu_wr_done;

    // ------------------------------------------------------------------
    // Access sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rdy        = 1'b0;
        ldr_gnt    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // Loader takes priority so a bulk load is never starved by the CPU
                if (ldr_req) begin
                    state_next = ST_LOAD;
                end else if (mio_en) begin
                    state_next = ST_ACCESS;
                    cnt_next   = 4'(WAIT_STATES);
                end
            end
            ST_ACCESS: begin
                if (cnt_reg == 4'd0) begin
                    rdy        = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_LOAD: begin
                ldr_gnt = 1'b1;
                if (!ldr_req) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign cpu_rd_done = rdy & mio_en & ~rw;
    assign cpu_wr_done = rdy & mio_en & rw;

    // ------------------------------------------------------------------
    // Address decode and read-data selection
    // ------------------------------------------------------------------
    assign mar_is_mem = (mar_reg < DEV_BASE);

    genvar gi;
    generate
        for (gi = 0; gi < N_DEV; gi++) begin : g_dev_sel
            assign dev_sel[gi] = !mar_is_mem && (mar_reg == DEV_ADDR[gi]);
        end
    endgenerate

    always_comb begin
        dev_rdata = 16'h0000;
        if (dev_sel[DEV_KBSR]) dev_rdata = {kb_ready_reg, kb_ie_reg, 14'h0000};
        if (dev_sel[DEV_KBDR]) dev_rdata = {8'h00, kbdr_reg};
        if (dev_sel[DEV_DSR])  dev_rdata = {dsr_ready_reg, 15'h0000};
        if (dev_sel[DEV_DDR])  dev_rdata = ddr_reg;
        if (dev_sel[DEV_MCR])  dev_rdata = mcr_reg;
    end

    assign rd_data = mar_is_mem ? sram_rdata : dev_rdata;

    // ------------------------------------------------------------------
    // SRAM port: loader owns it in LOAD, otherwise MAR/MDR drive it
    // ------------------------------------------------------------------
    always_comb begin
        if (ldr_gnt) begin
            sram_addr  = ldr_addr;
            sram_wdata = ldr_wdata;
            sram_we    = ldr_we & (ldr_addr < DEV_BASE);
        end else begin
            sram_addr  = mar_reg;
            sram_wdata = mdr_reg;
            sram_we    = cpu_wr_done & mar_is_mem;
        end
    end

    assign ldr_rdata = ldr_gnt ? sram_rdata : 16'h0000;

    // ------------------------------------------------------------------
    // MAR / MDR and the bus driver
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mar_reg <= 16'h0000;
        end else if (ld_mar) begin
            mar_reg <= bus;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mdr_reg <= 16'h0000;
        end else if (ld_mdr && !mio_en) begin
            mdr_reg <= bus;
        end else if (ld_mdr && cpu_rd_done) begin
            mdr_reg <= rd_data;
        end
    end

    assign bus = gate_mdr ? mdr_reg : 16'hzzzz;

    // ------------------------------------------------------------------
    // Keyboard registers: a new character beats a coincident KBDR read
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            kb_ready_reg <= 1'b0;
            kbdr_reg     <= 8'h00;
        end else if (kb_valid) begin
            kb_ready_reg <= 1'b1;
            kbdr_reg     <= kb_data;
        end else if (cpu_rd_done && dev_sel[DEV_KBDR]) begin
            kb_ready_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            kb_ie_reg <= 1'b0;
        end else if (cpu_wr_done && dev_sel[DEV_KBSR]) begin
            kb_ie_reg <= mdr_reg[14];
        end
    end

    assign kb_int = kb_ready_reg & kb_ie_reg;

    // ------------------------------------------------------------------
    // Display registers: a DDR write beats a coincident acknowledge
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ddr_reg       <= 16'h0000;
            dsr_ready_reg <= 1'b1;
            dsp_valid_reg <= 1'b0;
        end else if (cpu_wr_done && dev_sel[DEV_DDR]) begin
            ddr_reg       <= mdr_reg;
            dsr_ready_reg <= 1'b0;
            dsp_valid_reg <= 1'b1;
        end else if (dsp_ack && dsp_valid_reg) begin
            dsr_ready_reg <= 1'b1;
            dsp_valid_reg <= 1'b0;
        end
    end

    assign dsp_valid = dsp_valid_reg;
    assign dsp_data  = ddr_reg[7:0];

    // ------------------------------------------------------------------
    // Machine control register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mcr_reg <= 16'h8000;
        end else if (cpu_wr_done && dev_sel[DEV_MCR]) begin
            mcr_reg <= mdr_reg;
        end
    end

    assign mcr_run = mcr_reg[15];

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Bench for lc3_mem_ctrl: directed scenarios then random CPU/keyboard/display traffic,
// checked against a register-map and memory model held in the bench.
module tb_lc3_mem_ctrl;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        arst_n;
    wire  [15:0] bus;
    logic [15:0] tb_bus;
    logic        tb_drv;
    logic        ld_mar, ld_mdr, gate_mdr, mio_en, rw;
    logic        rdy;
    logic [15:0] sram_addr, sram_wdata, sram_rdata;
    logic        sram_we;
    logic        ldr_req, ldr_gnt, ldr_we;
    logic [15:0] ldr_addr, ldr_wdata, ldr_rdata;
    logic        kb_valid;
    logic [7:0]  kb_data;
    logic        kb_int, dsp_valid;
    logic [7:0]  dsp_data;
    logic        dsp_ack, mcr_run;

    int checks = 0;
    int errors = 0;
    int we_count = 0;

    always #5 clk = ~clk;

    assign bus = tb_drv ? tb_bus : 16'hzzzz;

    lc3_mem_ctrl #(.WAIT_STATES(WS), .DEV_BASE(16'hFE00)) dut (
        .clk(clk), .arst_n(arst_n), .bus(bus),
        .ld_mar(ld_mar), .ld_mdr(ld_mdr), .gate_mdr(gate_mdr),
        .mio_en(mio_en), .rw(rw), .rdy(rdy),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .sram_we(sram_we),
        .ldr_req(ldr_req), .ldr_gnt(ldr_gnt), .ldr_we(ldr_we),
        .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_rdata(ldr_rdata),
        .kb_valid(kb_valid), .kb_data(kb_data), .kb_int(kb_int),
        .dsp_valid(dsp_valid), .dsp_data(dsp_data), .dsp_ack(dsp_ack),
        .mcr_run(mcr_run)
    );

    // External SRAM: combinational read, write on the clock edge
    function automatic logic [15:0] sram_init(input logic [15:0] a);
        return (a == 16'h3000) ? 16'h1234 : (a ^ 16'h5A5A);
    endfunction

    logic [15:0] sram_mem [65536];
    bit          sram_written [65536] = '{default: 1'b0};

    assign sram_rdata = sram_written[sram_addr] ? sram_mem[sram_addr] : sram_init(sram_addr);

    always @(posedge clk) begin
        if (sram_we) begin
            sram_mem[sram_addr]     <= sram_wdata;
            sram_written[sram_addr] <= 1'b1;
            we_count                <= we_count + 1;
        end
    end

    // Reference model
    bit          m_kb_ready, m_kb_ie, m_dsr_ready, m_dsp_valid;
    logic [7:0]  m_kbdr;
    logic [15:0] m_ddr, m_mcr;
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] wr_q [$];

    function automatic logic [15:0] model_read(input logic [15:0] a);
        if (a < 16'hFE00) return ref_mem.exists(a) ? ref_mem[a] : sram_init(a);
        case (a)
            16'hFE00: return {m_kb_ready, m_kb_ie, 14'h0};
            16'hFE02: return {8'h00, m_kbdr};
            16'hFE04: return {m_dsr_ready, 15'h0};
            16'hFE06: return m_ddr;
            16'hFFFE: return m_mcr;
            default:  return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        m_kb_ready = 0; m_kb_ie = 0; m_kbdr = 8'h00;
        m_dsr_ready = 1; m_ddr = 16'h0000; m_dsp_valid = 0;
        m_mcr = 16'h8000;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_status();
        check("kb_int",    {15'h0, kb_int},    {15'h0, m_kb_ready & m_kb_ie});
        check("dsp_valid", {15'h0, dsp_valid}, {15'h0, m_dsp_valid});
        check("dsp_data",  {8'h0, dsp_data},   {8'h0, m_ddr[7:0]});
        check("mcr_run",   {15'h0, mcr_run},   {15'h0, m_mcr[15]});
    endtask

    task automatic kb_pulse(input logic [7:0] ch);
        kb_valid = 1; kb_data = ch;
        @(negedge clk);
        kb_valid = 0;
        m_kb_ready = 1; m_kbdr = ch;
        $display("kb_pulse char=%h", ch);
    endtask

    task automatic ack_pulse();
        dsp_ack = 1;
        @(negedge clk);
        dsp_ack = 0;
        if (m_dsp_valid) begin m_dsp_valid = 0; m_dsr_ready = 1; end
        $display("dsp_ack");
    endtask

    // Full CPU access: load MAR (and MDR for writes), hold mio_en until rdy,
    // optionally strobe kb_valid / dsp_ack in the rdy cycle.
    task automatic cpu_access(input logic [15:0] addr, input bit wr, input logic [15:0] wdata,
                              input bit kb_at_rdy, input logic [7:0] kb_char, input bit ack_at_rdy);
        logic [15:0] exp_rd;
        bit          is_mem;
        int          cycles;
        int          we0;
        tb_drv = 1; tb_bus = addr; ld_mar = 1;
        @(negedge clk);
        ld_mar = 0;
        if (wr) begin
            tb_bus = wdata; ld_mdr = 1;
            @(negedge clk);
            ld_mdr = 0;
        end
        tb_drv = 0;
        exp_rd = model_read(addr);
        is_mem = (addr < 16'hFE00);
        we0 = we_count;
        mio_en = 1; rw = wr; ld_mdr = !wr;
        cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cycles++;
            if (rdy) break;
        end
        check("latency", 16'(cycles), 16'(WS + 1));
        check("we_in_rdy", {15'h0, sram_we}, {15'h0, wr & is_mem});
        if (wr && is_mem) begin
            check("we_addr", sram_addr, addr);
            check("we_data", sram_wdata, wdata);
        end
        check("we_early", 16'(we_count), 16'(we0));
        kb_valid = kb_at_rdy; kb_data = kb_char; dsp_ack = ack_at_rdy;
        @(negedge clk);
        kb_valid = 0; dsp_ack = 0; mio_en = 0; rw = 0; ld_mdr = 0;
        check("rdy_pulse", {15'h0, rdy}, 16'h0000);
        check("we_count", 16'(we_count), 16'(we0 + ((wr && is_mem) ? 1 : 0)));
        // Model update: KBDR read clear, then new char, ack, then a DDR write last
        if (!wr && addr == 16'hFE02) m_kb_ready = 0;
        if (kb_at_rdy) begin m_kb_ready = 1; m_kbdr = kb_char; end
        if (ack_at_rdy && m_dsp_valid) begin m_dsp_valid = 0; m_dsr_ready = 1; end
        if (wr) begin
            if (is_mem) ref_mem[addr] = wdata;
            else if (addr == 16'hFE00) m_kb_ie = wdata[14];
            else if (addr == 16'hFE06) begin m_ddr = wdata; m_dsr_ready = 0; m_dsp_valid = 1; end
            else if (addr == 16'hFFFE) m_mcr = wdata;
        end else begin
            gate_mdr = 1;
            #1;
            check("rd_data", bus, exp_rd);
            gate_mdr = 0;
        end
        check_status();
        $display("cpu %s addr=%h wdata=%h exp_rd=%h lat=%0d kb=%0b ack=%0b",
                 wr ? "WR" : "RD", addr, wdata, exp_rd, cycles, kb_at_rdy, ack_at_rdy);
    endtask

    logic [15:0] dev_list [6] = '{16'hFE00, 16'hFE02, 16'hFE04, 16'hFE06, 16'hFFFE, 16'hFE08};

    initial begin
        int          cycles;
        int          we0;
        int          op;
        logic [15:0] a;
        logic [15:0] d;
        arst_n = 0; tb_drv = 0; tb_bus = 0;
        ld_mar = 0; ld_mdr = 0; gate_mdr = 0; mio_en = 0; rw = 0;
        ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
        kb_valid = 0; kb_data = 0; dsp_ack = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_rdy", {15'h0, rdy}, 16'h0);
        check("rst_gnt", {15'h0, ldr_gnt}, 16'h0);
        check("rst_we", {15'h0, sram_we}, 16'h0);
        check_status();
        arst_n = 1;
        @(negedge clk);
        gate_mdr = 1;
        #1;
        check("rst_mdr", bus, 16'h0000);
        gate_mdr = 0;
        $display("reset checked");

        // Basic SRAM read and write
        cpu_access(16'h3000, 0, 16'h0, 0, 8'h0, 0);
        cpu_access(16'h3001, 1, 16'hBEEF, 0, 8'h0, 0);
        cpu_access(16'h3001, 0, 16'h0, 0, 8'h0, 0);

        // Keyboard
        kb_pulse(8'h41);
        cpu_access(16'hFE00, 0, 16'h0, 0, 8'h0, 0);
        cpu_access(16'hFE02, 0, 16'h0, 0, 8'h0, 0);
        cpu_access(16'hFE00, 0, 16'h0, 0, 8'h0, 0);
        cpu_access(16'hFE00, 1, 16'h4000, 0, 8'h0, 0);
        kb_pulse(8'h43);
        check_status();
        cpu_access(16'hFE02, 0, 16'h0, 1, 8'h44, 0);
        cpu_access(16'hFE00, 0, 16'h0, 0, 8'h0, 0);
        cpu_access(16'hFE02, 0, 16'h0, 0, 8'h0, 0);

        // Display
        cpu_access(16'hFE06, 1, 16'h0058, 0, 8'h0, 0);
        cpu_access(16'hFE04, 0, 16'h0, 0, 8'h0, 0);
        ack_pulse();
        check_status();
        cpu_access(16'hFE04, 0, 16'h0, 0, 8'h0, 0);
        cpu_access(16'hFE06, 1, 16'h0059, 0, 8'h0, 0);
        cpu_access(16'hFE06, 1, 16'h005A, 0, 8'h0, 1);
        cpu_access(16'hFE04, 0, 16'h0, 0, 8'h0, 0);

        // Loader wins a tie with the CPU, then the stalled CPU read completes
        tb_drv = 1; tb_bus = 16'h3000; ld_mar = 1;
        @(negedge clk);
        ld_mar = 0; tb_drv = 0;
        check("ldr_rdata_idle", ldr_rdata, 16'h0000);
        ldr_req = 1; mio_en = 1; rw = 0; ld_mdr = 1; ldr_addr = 16'h3000; ldr_we = 0;
        @(negedge clk);
        check("ldr_gnt", {15'h0, ldr_gnt}, 16'h0001);
        check("ldr_rdy", {15'h0, rdy}, 16'h0000);
        check("ldr_rdata", ldr_rdata, model_read(16'h3000));
        we0 = we_count;
        ldr_we = 1; ldr_wdata = 16'h5020;
        #1;
        check("ldr_we", {15'h0, sram_we}, 16'h0001);
        check("ldr_addr", sram_addr, 16'h3000);
        check("ldr_wdata", sram_wdata, 16'h5020);
        @(negedge clk);
        ldr_addr = 16'hFE06; ldr_wdata = 16'h1111;
        #1;
        check("ldr_dev_we", {15'h0, sram_we}, 16'h0000);
        @(negedge clk);
        ldr_we = 0; ldr_addr = 16'h3000;
        ref_mem[16'h3000] = 16'h5020;
        #1;
        check("ldr_we_count", 16'(we_count), 16'(we0 + 1));
        check("ldr_readback", ldr_rdata, 16'h5020);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ldr_stall", {15'h0, rdy}, 16'h0000);
        end
        check_status();
        ldr_req = 0;
        cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cycles++;
            if (rdy) break;
        end
        // One IDLE cycle after the loader releases, then the normal WS+1 latency
        check("ldr_resume_lat", 16'(cycles), 16'(WS + 2));
        check("ldr_gnt_off", {15'h0, ldr_gnt}, 16'h0000);
        check("ldr_rdata_off", ldr_rdata, 16'h0000);
        @(negedge clk);
        mio_en = 0; ld_mdr = 0;
        gate_mdr = 1;
        #1;
        check("ldr_cpu_rd", bus, 16'h5020);
        gate_mdr = 0;
        $display("loader sequence done lat=%0d", cycles);

        // Machine control
        cpu_access(16'hFFFE, 1, 16'h0000, 0, 8'h0, 0);
        cpu_access(16'hFFFE, 0, 16'h0, 0, 8'h0, 0);

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 5);
            d  = 16'($urandom);
            case (op)
                0: begin
                    a = 16'($urandom_range(0, 16'hFDFF));
                    wr_q.push_back(a);
                    cpu_access(a, 1, d, $urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 3) == 0);
                end
                1: begin
                    if (wr_q.size() > 0 && $urandom_range(0, 1) == 1)
                        a = wr_q[$urandom_range(0, wr_q.size() - 1)];
                    else
                        a = 16'($urandom_range(0, 16'hFDFF));
                    cpu_access(a, 0, 16'h0, $urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 3) == 0);
                end
                2: cpu_access(dev_list[$urandom_range(0, 5)], 1, d,
                              $urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 2) == 0);
                3: cpu_access(dev_list[$urandom_range(0, 5)], 0, 16'h0,
                              $urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 3) == 0);
                4: kb_pulse(8'($urandom));
                default: ack_pulse();
            endcase
        end

        // Reset in the middle of a write access
        tb_drv = 1; tb_bus = 16'h3100; ld_mar = 1;
        @(negedge clk);
        ld_mar = 0; tb_bus = 16'hCAFE; ld_mdr = 1;
        @(negedge clk);
        ld_mdr = 0; tb_drv = 0;
        we0 = we_count;
        mio_en = 1; rw = 1;
        @(negedge clk);
        @(negedge clk);
        arst_n = 0;
        #1;
        check("arst_rdy", {15'h0, rdy}, 16'h0000);
        check("arst_we", {15'h0, sram_we}, 16'h0000);
        mio_en = 0; rw = 0;
        @(negedge clk);
        @(negedge clk);
        check("arst_no_write", 16'(we_count), 16'(we0));
        model_reset();
        check_status();
        arst_n = 1;
        @(negedge clk);
        $display("reset mid-access done");
        cpu_access(16'hFFFE, 0, 16'h0, 0, 8'h0, 0);
        cpu_access(16'hFE04, 0, 16'h0, 0, 8'h0, 0);
        cpu_access(16'h3100, 0, 16'h0, 0, 8'h0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
